// File: rtl/button_debounce.sv
// button_debounce
// Turns one raw, active-low push-button into a clean active-high level plus
// single-cycle press and release pulses. The raw key goes through a two-flop
// synchroniser, and a four-state FSM then accepts a change only after the
// synchronised input has held its new value for DEBOUNCE_CYCLES clocks.
`timescale 1ns/1ps

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  // Counter width is derived from the cycle count and is not meant to be overridden.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_e;

  logic       sync1_q;
  logic       sync2_q;
  logic       pressed_s;

  state_e     state_q;
  state_e     state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic       press_q;
  logic       press_d;
  logic       release_q;
  logic       release_d;
  logic       level_s;

  // Two-flop synchroniser; only sync1_q ever sees the asynchronous key, and it
  // resets to the released (high) value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  // State register, stability counter and the registered output pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic: a wait state either falls back on an opposite sample,
  // accepts once the counter has reached its limit, or keeps counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RELEASED: begin
        if (pressed_s) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (!pressed_s) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: the level follows the state register directly, and a pulse
  // is requested exactly on the accepting transition so that it lands in the
  // same cycle as the level edge.
  always_comb begin
    level_s   = (state_q == S_PRESSED) || (state_q == S_RELEASE_WAIT);
    press_d   = (state_q == S_PRESS_WAIT)   && (state_d == S_PRESSED);
    release_d = (state_q == S_RELEASE_WAIT) && (state_d == S_RELEASED);
  end

  assign o_level   = level_s;
  assign o_press   = press_q;
  assign o_release = release_q;

  // Press and release pulses can never coincide.
  assert property (@(posedge clk) disable iff (!reset_n) !(o_press && o_release));

  // The stability counter stays within its qualification range.
  assert property (@(posedge clk) disable iff (!reset_n) cnt_q <= CNT_MAX);

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
// Drives two debouncers (4-cycle and 1-cycle qualification) from one key.
// The expected outputs come from a fixed table for a clean press and release,
// from hand-written corner-case sequences, and from a streak-based reference
// model: after two sync delays, the level flips once the opposite value has been
// seen on DEBOUNCE_CYCLES+1 consecutive edges.
`timescale 1ns/1ps

module tb_button_debounce;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic keyN = 1'b1;

  logic level4, press4, release4;
  logic level1, press1, release1;

  int vecCount = 0;
  int missCount = 0;
  int pressCnt4 = 0;
  int releaseCnt4 = 0;
  int pressCnt1 = 0;

  // Reference model state.
  bit mKey1 = 1'b1;
  bit mKey2 = 1'b1;
  bit mLevel[2];
  int mStreak[2];
  bit mPress[2];
  bit mRelease[2];

  typedef struct {
    bit keyN;
    bit expLevel;
    bit expPress;
    bit expRelease;
  } vec_t;

  vec_t table4[22];

  button_debounce #(.DEBOUNCE_CYCLES(4)) dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_key_n   (keyN),
    .o_level   (level4),
    .o_press   (press4),
    .o_release (release4)
  );

  button_debounce #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_key_n   (keyN),
    .o_level   (level1),
    .o_press   (press1),
    .o_release (release1)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic int cyclesOf(input int idx);
    return (idx == 0) ? 4 : 1;
  endfunction

  task automatic modelReset();
    mKey1 = 1'b1;
    mKey2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mLevel[i] = 1'b0;
      mStreak[i] = 0;
      mPress[i] = 1'b0;
      mRelease[i] = 1'b0;
    end
  endtask

  // One clock edge of the model: the FSM sees the key value from two edges ago.
  task automatic modelStep();
    bit p;
    p = ~mKey2;
    mKey2 = mKey1;
    mKey1 = keyN;
    for (int i = 0; i < 2; i++) begin
      mPress[i] = 1'b0;
      mRelease[i] = 1'b0;
      if (p != mLevel[i]) begin
        mStreak[i]++;
        if (mStreak[i] == cyclesOf(i) + 1) begin
          mLevel[i] = p;
          if (p) mPress[i] = 1'b1;
          else   mRelease[i] = 1'b1;
          mStreak[i] = 0;
        end
      end else begin
        mStreak[i] = 0;
      end
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkBit("level4",   level4,   mLevel[0]);
    checkBit("press4",   press4,   mPress[0]);
    checkBit("release4", release4, mRelease[0]);
    checkBit("level1",   level1,   mLevel[1]);
    checkBit("press1",   press1,   mPress[1]);
    checkBit("release1", release1, mRelease[1]);
  endtask

  // Drive the key, advance one clock edge, and compare against the model.
  task automatic applyStimulus(input bit key);
    keyN = key;
    @(posedge clk);
    if (reset_n) modelStep();
    #1;
    if (press4)   pressCnt4++;
    if (release4) releaseCnt4++;
    if (press1)   pressCnt1++;
    checkOutput();
  endtask

  task automatic pulseReset();
    reset_n = 1'b0;
    modelReset();
    #1;
    checkBit("rst_level4", level4, 1'b0);
    checkBit("rst_press4", press4, 1'b0);
    checkBit("rst_level1", level1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Hold the key and count edges (including the first) until the level rises.
  task automatic edgesToRise(input int idx, input bit key, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(key);
      if ((idx == 0 && level4) || (idx == 1 && level1)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int p0;
    int r0;

    table4 = '{
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1}, '{1'b1, 1'b0, 1'b0, 1'b0}
    };

    modelReset();
    reset_n = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle with the key released: everything stays low.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1);

    // Clean press then clean release against fixed expectations.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(table4[i].keyN);
      checkBit($sformatf("tbl%0d_level", i),   level4,   table4[i].expLevel);
      checkBit($sformatf("tbl%0d_press", i),   press4,   table4[i].expPress);
      checkBit($sformatf("tbl%0d_release", i), release4, table4[i].expRelease);
    end

    // Bounce 0,1,0,1 two cycles each, then stable 0: one press, 7 edges after the last fall.
    p0 = pressCnt4;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
    end
    checkBit("bounce_no_level", level4, 1'b0);
    edgesToRise(0, 1'b0, n);
    checkInt("bounce_latency", n, 7);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0);
    checkInt("bounce_press_count", pressCnt4 - p0, 1);

    // A 3-cycle release glitch while pressed is ignored.
    r0 = releaseCnt4;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0);
    checkBit("glitch_level", level4, 1'b1);
    checkInt("glitch_release_count", releaseCnt4 - r0, 0);

    // Clean release: exactly one release pulse.
    for (int i = 0; i < 12; i++) applyStimulus(1'b1);
    checkBit("release_level", level4, 1'b0);
    checkInt("release_count", releaseCnt4 - r0, 1);

    // Reset in the middle of press qualification, with the key held throughout.
    p0 = pressCnt4;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0);
    pulseReset();
    checkInt("midreset_no_press", pressCnt4 - p0, 0);
    edgesToRise(0, 1'b0, n);
    checkInt("midreset_latency", n, 7);
    checkBit("midreset_press", press4, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1);

    // Random key runs with occasional asynchronous resets.
    for (int i = 0; i < 120; i++) begin
      bit k;
      int len;
      k = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) applyStimulus(k);
      if ($urandom_range(0, 19) == 0) pulseReset();
    end

    // One-cycle qualification: level rises 4 edges after the key falls.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1);
    pulseReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1);
    p0 = pressCnt1;
    edgesToRise(1, 1'b0, n);
    checkInt("d1_latency", n, 4);
    checkInt("d1_press_count", pressCnt1 - p0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
